request_responder: RTL and testbench
====================================

# request_responder

Target side of the single-cycle begin/end request handshake. It accepts a one-cycle `request_begin` pulse with address, write data and byte strobes, and services it against an internal word-addressed register bank. After a fixed latency it returns a one-cycle `request_end` pulse with read data and an error flag. It sits behind an initiator's request-pending tracker and acts as the simple peripheral or memory stub those initiators talk to.

## Interface
- `ADDR_WIDTH`, 4: word address width.
- `NUM_WORDS`, 12: implemented words, 1..2^ADDR_WIDTH. Addresses >= NUM_WORDS are error responses.
- `LATENCY`, 2: cycles from the `request_begin` cycle to the `request_end` cycle, >= 1.

- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `request_begin`  in  1  one-cycle request strobe.
- `request_we`  in  1  1 = write, 0 = read; sampled with `request_begin`.
- `request_addr`  in  ADDR_WIDTH  word address; sampled with `request_begin`.
- `request_wdata`  in  32  write data; sampled with `request_begin`.
- `request_wstrb`  in  4  byte enables, bit i -> bits [8i+7:8i]; sampled with `request_begin`.
- `request_end`  out  1  one-cycle completion strobe (registered).
- `request_rdata`  out  32  read data, valid only while `request_end`=1, otherwise 0.
- `request_error`  out  1  address out of range, valid only while `request_end`=1, otherwise 0.
- `busy`  out  1  request in flight; high from the cycle after an accepted begin through its end cycle.
- `protocol_violation`  out  1  sticky; set on a begin that is not accepted; cleared only by reset.

## Operation
- States:
  - IDLE: no request.
  - WAIT: latency counter running.
  - DONE: `request_end`=1 this cycle.
- Capture: on an accepted begin, latch we/addr/wdata/wstrb. Latched fields are held until DONE; inputs are ignored in between.
- IDLE + begin:
  - go to DONE if LATENCY=1;
  - otherwise go to WAIT with counter = LATENCY-1.
- WAIT: decrement the counter; when it reaches 1 at a clock edge, go to DONE. The counter is clog2(LATENCY+1) bits and never wraps.
- DONE, completion at the edge entering DONE:
  - read, addr < NUM_WORDS: `request_rdata` = word[addr].
  - write, addr < NUM_WORDS: word[addr] bytes with strb=1 updated; rdata = 0.
  - addr >= NUM_WORDS: no register change; rdata = 0; `request_error`=1.
- DONE exit:
  - with `request_begin`=1 in the DONE cycle, the new request is accepted (back-to-back). Next state is DONE (LATENCY=1) or WAIT.
  - without begin, go to IDLE.
- Acceptance: a begin is accepted only in IDLE or DONE. A begin in WAIT is dropped, sets `protocol_violation`, and the current request completes unaffected.
- Read-after-write: a read accepted in the DONE cycle of a write returns the newly written value.
- Reset (`reset`=0 at any edge):
  - state IDLE, counter 0, all words 0;
  - `request_end`, `request_rdata`, `request_error`, `busy` and `protocol_violation` all 0.
  - A request in flight is discarded and no `request_end` is produced.
  - A begin in the same cycle as reset is ignored.

## Timing
- Begin sampled at edge E0. `request_end` is high for exactly the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after the begin cycle. Example, LATENCY=2: begin in cycle 0, end in cycle 2.
- `busy` covers cycles 1..LATENCY. It stays high continuously across back-to-back requests.
- Sustained throughput: one request per LATENCY cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset then idle: `reset`=0 for 3 cycles, release. Required: all outputs 0; reads of addr 0..11 return 0 with error=0.
- Write/read, LATENCY=2: write addr 3, wdata 0xDEADBEEF, wstrb 4'hF in cycle 0. Required: end in cycle 2 with rdata 0. Read addr 3 in cycle 3, then end in cycle 5 with rdata 0xDEADBEEF, error 0.
- Byte strobes: write 0x11223344 wstrb 4'b0101 over 0xDEADBEEF. Required: readback 0xDE22BE44.
- Back-to-back: read begin issued in the DONE cycle of a write to addr 5 (0xA5A5A5A5). Required: read accepted, `busy` never drops, and the second end returns 0xA5A5A5A5.
- Error and violation:
  - Read addr 12: required end with error=1, rdata 0.
  - Begin in the WAIT cycle: required `protocol_violation`=1 (sticky), exactly one end, no register change from the dropped write.
- Reset mid-request: assert reset in cycle 1 of a LATENCY=3 write. Required: no `request_end`, and the target word reads 0 afterwards.

Source files
------------

// File: rtl/request_responder.sv
// Target side of the begin/end request handshake: fixed-latency access to a small
// word-addressed register bank with byte strobes, range errors and a sticky violation flag.
module request_responder #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_WORDS  = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  request_begin,
    input  logic                  request_we,
    input  logic [ADDR_WIDTH-1:0] request_addr,
    input  logic [31:0]           request_wdata,
    input  logic [3:0]            request_wstrb,
    output logic                  request_end,
    output logic [31:0]           request_rdata,
    output logic                  request_error,
    output logic                  busy,
    output logic                  protocol_violation
);

    localparam int unsigned CNT_WIDTH = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           mem_q [NUM_WORDS];
    logic [31:0]           mem_d [NUM_WORDS];
    logic [31:0]           rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic                  viol_q, viol_d;
    logic                  accept;
    logic                  capture;

    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_wstrb;
    logic                  cur_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        viol_d  = viol_q;
        rdata_d = '0;
        error_d = 1'b0;
        mem_d   = mem_q;
        accept  = request_begin && (state_q == StIdle || state_q == StDone);

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    end
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (request_begin) viol_d = 1'b1;
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // With LATENCY=1 the request completes on the same edge that captures it.
        cur_we    = capture ? request_we    : we_q;
        cur_addr  = capture ? request_addr  : addr_q;
        cur_wdata = capture ? request_wdata : wdata_q;
        cur_wstrb = capture ? request_wstrb : wstrb_q;
        cur_ok    = 32'(cur_addr) < NUM_WORDS;

        if (state_d == StDone) begin
            if (!cur_ok) begin
                error_d = 1'b1;
            end else if (cur_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (cur_wstrb[b]) mem_d[cur_addr][8*b +: 8] = cur_wdata[8*b +: 8];
                end
            end else begin
                rdata_d = mem_q[cur_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            viol_q  <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            viol_q  <= viol_d;
            mem_q   <= mem_d;
            if (capture) begin
                we_q    <= request_we;
                addr_q  <= request_addr;
                wdata_q <= request_wdata;
                wstrb_q <= request_wstrb;
            end
        end
    end

    assign request_end        = (state_q == StDone);
    assign busy               = (state_q != StIdle);
    assign request_rdata      = rdata_q;
    assign request_error      = error_q;
    assign protocol_violation = viol_q;

endmodule

// File: tb/tb_request_responder.sv
// Directed bench for request_responder: LATENCY=2 instance for function, LATENCY=3 for reset abort.
module tb_request_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_begin;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_end;
    logic [31:0] req_rdata;
    logic        req_error;
    logic        busy;
    logic        viol;

    logic        reset3;
    logic        begin3;
    logic        end3;
    logic [31:0] rdata3;
    logic        error3;
    logic        busy3;
    logic        viol3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    request_responder #(.ADDR_WIDTH(4), .NUM_WORDS(12), .LATENCY(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .request_begin      (req_begin),
        .request_we         (req_we),
        .request_addr       (req_addr),
        .request_wdata      (req_wdata),
        .request_wstrb      (req_wstrb),
        .request_end        (req_end),
        .request_rdata      (req_rdata),
        .request_error      (req_error),
        .busy               (busy),
        .protocol_violation (viol)
    );

    request_responder #(.ADDR_WIDTH(4), .NUM_WORDS(12), .LATENCY(3)) dut3 (
        .clk                (clk),
        .reset              (reset3),
        .request_begin      (begin3),
        .request_we         (req_we),
        .request_addr       (req_addr),
        .request_wdata      (req_wdata),
        .request_wstrb      (req_wstrb),
        .request_end        (end3),
        .request_rdata      (rdata3),
        .request_error      (error3),
        .busy               (busy3),
        .protocol_violation (viol3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change #1 after the edge, so outputs are stable when sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
    endtask

    // One request on the LATENCY=2 instance; leaves the bench in the cycle after DONE.
    task automatic req(input logic we, input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd, output logic er);
        int n;
        drive(we, a, wd, ws);
        req_begin = 1'b1;
        step();
        req_begin = 1'b0;
        n = 0;
        while (!req_end && n < 10) begin
            step();
            n++;
        end
        check("req_latency", n, 1);
        rd = req_rdata;
        er = req_error;
        step();
        check("req_end_pulse", {31'd0, req_end}, 0);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset     = 1'b0;
        reset3    = 1'b0;
        req_begin = 1'b0;
        begin3    = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 4'd0);
        step();
        step();
        req_begin = 1'b1;  // begin during reset must be ignored
        step();
        reset     = 1'b1;
        reset3    = 1'b1;
        req_begin = 1'b0;
        check("rst_end",   {31'd0, req_end}, 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_error", {31'd0, req_error}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_viol",  {31'd0, viol}, 0);
        step();
        check("rst_begin_ignored", {31'd0, busy}, 0);

        for (int i = 0; i < 12; i++) begin
            req(1'b0, 4'(i), 32'd0, 4'd0, rd, er);
            check("init_rdata", rd, 0);
            check("init_error", {31'd0, er}, 0);
        end

        // Write then read with explicit cycle checks.
        drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        req_begin = 1'b1;
        step();
        req_begin = 1'b0;
        check("wr_c1_busy", {31'd0, busy}, 1);
        check("wr_c1_end",  {31'd0, req_end}, 0);
        step();
        check("wr_c2_end",   {31'd0, req_end}, 1);
        check("wr_c2_rdata", req_rdata, 0);
        step();
        check("wr_c3_busy", {31'd0, busy}, 0);
        req(1'b0, 4'd3, 32'd0, 4'd0, rd, er);
        check("rd3_data",  rd, 32'hDEADBEEF);
        check("rd3_error", {31'd0, er}, 0);

        req(1'b1, 4'd3, 32'h11223344, 4'b0101, rd, er);
        req(1'b0, 4'd3, 32'd0, 4'd0, rd, er);
        check("strb_data", rd, 32'hDE22BE44);

        // Back-to-back: read issued in the write's DONE cycle.
        drive(1'b1, 4'd5, 32'hA5A5A5A5, 4'hF);
        req_begin = 1'b1;
        step();
        req_begin = 1'b0;
        check("b2b_c1_busy", {31'd0, busy}, 1);
        step();
        check("b2b_c2_end", {31'd0, req_end}, 1);
        drive(1'b0, 4'd5, 32'd0, 4'd0);
        req_begin = 1'b1;
        step();
        req_begin = 1'b0;
        check("b2b_c3_busy", {31'd0, busy}, 1);
        check("b2b_c3_end",  {31'd0, req_end}, 0);
        step();
        check("b2b_c4_end",   {31'd0, req_end}, 1);
        check("b2b_c4_rdata", req_rdata, 32'hA5A5A5A5);
        check("b2b_c4_busy",  {31'd0, busy}, 1);
        step();
        check("b2b_c5_busy", {31'd0, busy}, 0);

        req(1'b0, 4'd12, 32'd0, 4'd0, rd, er);
        check("oor_error", {31'd0, er}, 1);
        check("oor_rdata", rd, 0);
        req(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF, rd, er);
        check("oor_wr_error", {31'd0, er}, 1);

        // Begin during WAIT is dropped; the latched request must not be disturbed.
        check("viol_pre", {31'd0, viol}, 0);
        drive(1'b1, 4'd7, 32'h12345678, 4'hF);
        req_begin = 1'b1;
        step();
        drive(1'b1, 4'd6, 32'hFFFFFFFF, 4'hF);
        step();
        req_begin = 1'b0;
        check("viol_end",  {31'd0, req_end}, 1);
        check("viol_flag", {31'd0, viol}, 1);
        step();
        check("viol_one_end_a", {31'd0, req_end}, 0);
        step();
        check("viol_one_end_b", {31'd0, req_end}, 0);
        check("viol_sticky",    {31'd0, viol}, 1);
        req(1'b0, 4'd6, 32'd0, 4'd0, rd, er);
        check("viol_dropped_wr", rd, 0);
        req(1'b0, 4'd7, 32'd0, 4'd0, rd, er);
        check("viol_kept_wr", rd, 32'h12345678);
        check("viol_sticky2", {31'd0, viol}, 1);

        // LATENCY=3 instance: normal write, then a write aborted by reset.
        drive(1'b1, 4'd1, 32'h0BADCAFE, 4'hF);
        begin3 = 1'b1;
        step();
        begin3 = 1'b0;
        step();
        check("l3_c2_end", {31'd0, end3}, 0);
        step();
        check("l3_c3_end", {31'd0, end3}, 1);
        step();
        drive(1'b1, 4'd2, 32'hCAFEF00D, 4'hF);
        begin3 = 1'b1;
        step();
        begin3 = 1'b0;
        reset3 = 1'b0;
        step();
        reset3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("l3_abort_no_end", {31'd0, end3}, 0);
            step();
        end
        drive(1'b0, 4'd2, 32'd0, 4'd0);
        begin3 = 1'b1;
        step();
        begin3 = 1'b0;
        step();
        step();
        check("l3_rd_end",   {31'd0, end3}, 1);
        check("l3_rd_data",  rdata3, 0);
        step();

        reset = 1'b0;
        step();
        reset = 1'b1;
        check("viol_cleared", {31'd0, viol}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
